fpu_cmd_sequencer: RTL and testbench

Command-side initiator for the FPU top: accepts register-file write and arithmetic-operation commands over a valid/ready interface, and drives the FPU's memory, load, enable and opcode pins in the correct order. It waits for the FPU's done pulse, captures the result and exception flags, and returns them over a valid/ready response channel. It sits between a host or bus-slave adapter and the FPU, so no host ever toggles `enable`/`ld` directly.

---
 rtl/fpu_cmd_sequencer_if.sv | 48 ++++
 rtl/fpu_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// fpu_cmd_sequencer_if
// Command and response channels between a host (or bus-slave adapter) and the
// FPU command sequencer. Both channels use a valid/ready handshake.
//
//   cmd_valid / cmd_ready : command handshake (host -> sequencer)
//   cmd_kind              : 0 = register WRITE, 1 = arithmetic OP
//   cmd_op, cmd_round     : FPU opcode and rounding mode
//   cmd_a, cmd_b, cmd_d   : source 1, source 2, destination register
//   cmd_data              : WRITE payload
//   rsp_valid / rsp_ready : response handshake (sequencer -> host)
//   rsp_data              : result word (WRITE echoes the payload)
//   rsp_flags             : {ov, un, inv, inexact, div_zero, less, eq, great, timeout}
//   rsp_err               : illegal opcode or watchdog expiry
//
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface fpu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_kind;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_round;
    logic [4:0]  cmd_a;
    logic [4:0]  cmd_b;
    logic [4:0]  cmd_d;
    logic [31:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [8:0]  rsp_flags;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_round, cmd_a, cmd_b, cmd_d, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_round, cmd_a, cmd_b, cmd_d, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/fpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_cmd_sequencer
// Command-side initiator for the FPU top. Accepts WRITE and OP commands on the
// host interface, sequences the FPU memory/load/enable/opcode pins, waits for
// the FPU done pulse, captures result and flags, and returns them on the
// response channel.
//
// Parameters:
//   EXEC_MIN    : EXEC cycles before fpu_done is honoured (skips the opcode
//                 register stage and the stale done pulse of the previous op)
//   TIMEOUT_CYC : EXEC watchdog limit; also the saturation value of exec_cnt
//
// Build option:
//   FPU_SEQ_TIMEOUT_EN : when defined, an OP that sees no qualifying done by
//                        exec_cnt == TIMEOUT_CYC returns rsp_err with the
//                        timeout flag set. When undefined, EXEC waits forever
//                        and the timeout flag is always 0.
//
// Ports:
//   clk, rstp        : clock, asynchronous active-low reset
//   host             : command/response channels (slave modport)
//   fpu_inp_o        : SRAM write data
//   fpu_addr1..3_o   : source 1 / source 2 / destination register addresses
//   fpu_opcode_o     : FPU opcode
//   fpu_round_o      : rounding mode
//   fpu_enable_o     : 0 = SRAM write cycle, 1 = normal operation
//   fpu_ld_o         : operand load strobe
//   fpu_out_i        : FPU result
//   fpu_*_i flags    : exception / compare flags, fpu_done_i completion pulse
//
// State table:
//   IDLE  | waiting for a command, FPU free-running into scratch register 0
//   WRITE | one-cycle SRAM write of cmd_data into cmd_a
//   LOAD0 | operand SRAM read
//   LOAD1 | operand register capture
//   EXEC  | waiting for a qualifying fpu_done (or the watchdog)
//   RESP  | response presented until rsp_ready
// -----------------------------------------------------------------------------
module fpu_cmd_sequencer #(
    parameter int EXEC_MIN    = 2,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                  clk,
    input  logic                  rstp,
    fpu_cmd_sequencer_if.slave    host,

    output logic [31:0]           fpu_inp_o,
    output logic [4:0]            fpu_addr1_o,
    output logic [4:0]            fpu_addr2_o,
    output logic [4:0]            fpu_addr3_o,
    output logic [2:0]            fpu_opcode_o,
    output logic [2:0]            fpu_round_o,
    output logic                  fpu_enable_o,
    output logic                  fpu_ld_o,

    input  logic [31:0]           fpu_out_i,
    input  logic                  fpu_ov_i,
    input  logic                  fpu_un_i,
    input  logic                  fpu_inv_i,
    input  logic                  fpu_inexact_i,
    input  logic                  fpu_div_zero_i,
    input  logic                  fpu_less_i,
    input  logic                  fpu_eq_i,
    input  logic                  fpu_great_i,
    input  logic                  fpu_done_i
);

    localparam logic [4:0] EXEC_MIN_C = 5'(EXEC_MIN);
    localparam logic [4:0] CNT_MAX_C  = 5'(TIMEOUT_CYC);
    localparam logic [2:0] OP_LAST_C  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_LOAD0 = 3'd2,
        S_LOAD1 = 3'd3,
        S_EXEC  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  op_q,        op_d;
    logic [2:0]  round_q,     round_d;
    logic [4:0]  a_q,         a_d;
    logic [4:0]  b_q,         b_d;
    logic [4:0]  d_q,         d_d;
    logic [31:0] data_q,      data_d;
    logic [4:0]  exec_cnt_q,  exec_cnt_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    logic [8:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_err_q,   rsp_err_d;

    logic        accept;
    logic        done_ok;
    logic [7:0]  fpu_flags;

    assign fpu_flags = {fpu_ov_i, fpu_un_i, fpu_inv_i, fpu_inexact_i,
                        fpu_div_zero_i, fpu_less_i, fpu_eq_i, fpu_great_i};

    // Gated with rstp so a command presented during reset is never accepted.
    assign host.cmd_ready = (state_q == S_IDLE) && rstp;
    assign accept         = host.cmd_valid && host.cmd_ready;

    // The done seen in the first EXEC cycles belongs to the previous operation.
    assign done_ok = fpu_done_i && (exec_cnt_q >= EXEC_MIN_C);

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            round_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            data_q      <= '0;
            exec_cnt_q  <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            round_q     <= round_d;
            a_q         <= a_d;
            b_q         <= b_d;
            d_q         <= d_d;
            data_q      <= data_d;
            exec_cnt_q  <= exec_cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        round_d     = round_q;
        a_d         = a_q;
        b_d         = b_q;
        d_d         = d_q;
        data_d      = data_q;
        exec_cnt_d  = '0;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!host.cmd_kind) begin
                        a_d     = host.cmd_a;
                        data_d  = host.cmd_data;
                        state_d = S_WRITE;
                    end else if (host.cmd_op <= OP_LAST_C) begin
                        op_d    = host.cmd_op;
                        round_d = host.cmd_round;
                        a_d     = host.cmd_a;
                        b_d     = host.cmd_b;
                        d_d     = host.cmd_d;
                        state_d = S_LOAD0;
                    end else begin
                        // Illegal opcode: answer immediately, FPU pins untouched.
                        rsp_data_d  = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end

            S_WRITE: begin
                rsp_data_d  = data_q;
                rsp_flags_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = S_RESP;
            end

            S_LOAD0: state_d = S_LOAD1;

            S_LOAD1: state_d = S_EXEC;

            S_EXEC: begin
                exec_cnt_d = (exec_cnt_q == CNT_MAX_C) ? exec_cnt_q : exec_cnt_q + 5'd1;
                if (done_ok) begin
                    rsp_data_d  = fpu_out_i;
                    rsp_flags_d = {fpu_flags, 1'b0};
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end
`ifdef FPU_SEQ_TIMEOUT_EN
                else if (exec_cnt_q == CNT_MAX_C) begin
                    rsp_data_d  = '0;
                    rsp_flags_d = 9'h001;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
`else
                // No watchdog in this build: EXEC waits for a qualifying done.
`endif
            end

            S_RESP: begin
                if (host.rsp_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign host.rsp_valid = (state_q == S_RESP);
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_flags = rsp_flags_q;
    assign host.rsp_err   = rsp_err_q;

    // Address/opcode pins simply present the latched command; only enable,
    // ld and the destination address depend on the state. Outside an OP the
    // destination is held at the scratch register 0.
    assign fpu_inp_o    = data_q;
    assign fpu_addr1_o  = a_q;
    assign fpu_addr2_o  = b_q;
    assign fpu_opcode_o = op_q;
    assign fpu_round_o  = round_q;
    assign fpu_enable_o = (state_q != S_WRITE);
    assign fpu_ld_o     = (state_q == S_LOAD0) || (state_q == S_LOAD1);
    assign fpu_addr3_o  = ((state_q == S_LOAD0) || (state_q == S_LOAD1) ||
                           (state_q == S_EXEC)) ? d_q : 5'd0;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
module tb_fpu_cmd_sequencer;

    logic clk = 1'b0;
    logic rstp;
    always #5 clk = ~clk;

    fpu_cmd_sequencer_if bus();

    logic [31:0] fpu_inp;
    logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
    logic [2:0]  fpu_opcode, fpu_round;
    logic        fpu_enable, fpu_ld;
    logic [31:0] fpu_out;
    logic [7:0]  mflags;   // {ov, un, inv, inexact, div_zero, less, eq, great}
    logic        fpu_done;

    fpu_cmd_sequencer dut (
        .clk            (clk),
        .rstp           (rstp),
        .host           (bus),
        .fpu_inp_o      (fpu_inp),
        .fpu_addr1_o    (fpu_addr1),
        .fpu_addr2_o    (fpu_addr2),
        .fpu_addr3_o    (fpu_addr3),
        .fpu_opcode_o   (fpu_opcode),
        .fpu_round_o    (fpu_round),
        .fpu_enable_o   (fpu_enable),
        .fpu_ld_o       (fpu_ld),
        .fpu_out_i      (fpu_out),
        .fpu_ov_i       (mflags[7]),
        .fpu_un_i       (mflags[6]),
        .fpu_inv_i      (mflags[5]),
        .fpu_inexact_i  (mflags[4]),
        .fpu_div_zero_i (mflags[3]),
        .fpu_less_i     (mflags[2]),
        .fpu_eq_i       (mflags[1]),
        .fpu_great_i    (mflags[0]),
        .fpu_done_i     (fpu_done)
    );

    // ---------------- FPU behavioural model ----------------
    logic [31:0] mem [32];
    logic [31:0] opa, opb;
    logic [2:0]  m_op;
    int          m_cnt;
    int          idle_div;
    logic        m_real;
    logic        m_kill;

    function automatic logic [39:0] compute(input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  f;
        r = 32'h0;
        f = 8'h0;
        case (op)
            3'd0: if (a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
            3'd1: if (a == 32'h40000000 && b == 32'h40400000) r = 32'h40C00000;
            3'd2: if (b == 32'h0) begin r = 32'h7F800000; f[3] = 1'b1; end
            3'd3: if (a == 32'h40800000) r = 32'h40000000;
            3'd4: f[2:0] = (a < b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
            default: r = 32'h0;
        endcase
        return {r, f};
    endfunction

    function automatic int latency(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3) ? 9 : 3;
    endfunction

    // Emits a garbage done pulse during each load cycle and every 8th idle
    // cycle, and a real done 'latency' cycles into EXEC.
    always @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            m_cnt    <= 0;
            fpu_done <= 1'b0;
            fpu_out  <= 32'h0;
            mflags   <= 8'h0;
            m_real   <= 1'b0;
            idle_div <= 0;
        end else begin
            fpu_done <= 1'b0;
            m_real   <= 1'b0;
            idle_div <= idle_div + 1;
            if (!fpu_enable) mem[fpu_addr1] <= fpu_inp;
            if (fpu_done && m_real) mem[fpu_addr3] <= fpu_out;
            if (fpu_ld) begin
                opa   <= mem[fpu_addr1];
                opb   <= mem[fpu_addr2];
                m_op  <= fpu_opcode;
                m_cnt <= latency(fpu_opcode);
                if (!m_kill) begin
                    fpu_done <= 1'b1;
                    fpu_out  <= 32'hDEADBEEF;
                    mflags   <= 8'hFF;
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !m_kill) begin
                    fpu_done          <= 1'b1;
                    m_real            <= 1'b1;
                    {fpu_out, mflags} <= compute(m_op, opa, opb);
                end
            end else if ((idle_div % 8) == 0 && !m_kill) begin
                fpu_done <= 1'b1;
                fpu_out  <= 32'hBADC0FFE;
                mflags   <= 8'hFF;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    task automatic send(input logic kind, input logic [2:0] op, input logic [2:0] rnd,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic [31:0] data);
        int waited;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = kind;
        bus.cmd_op    = op;
        bus.cmd_round = rnd;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_d     = d;
        bus.cmd_data  = data;
        waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) check("accept_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the fields: the sequencer must have latched them.
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = ~kind;
        bus.cmd_op    = 3'd7;
        bus.cmd_round = 3'd5;
        bus.cmd_a     = 5'd31;
        bus.cmd_b     = 5'd30;
        bus.cmd_d     = 5'd29;
        bus.cmd_data  = 32'hA5A5A5A5;
    endtask

    task automatic wait_rsp(input int bound, output int cyc, output logic ld_any);
        cyc    = 0;
        ld_any = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            ld_any |= fpu_ld;
        end while (!bus.rsp_valid && cyc < bound);
        if (!bus.rsp_valid) check("rsp_wait", 32'd0, 32'd1);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] data);
        int   cyc;
        logic ldx;
        send(1'b0, 3'd0, 3'd0, a, 5'd0, 5'd0, data);
        @(negedge clk);
        check("wr_enable", 32'(fpu_enable), 32'd0);
        check("wr_inp", fpu_inp, data);
        check("wr_addr1", 32'(fpu_addr1), 32'(a));
        wait_rsp(10, cyc, ldx);
        check("wr_lat", cyc, 1);
        check("wr_echo", bus.rsp_data, data);
        check("wr_flags", 32'(bus.rsp_flags), 32'd0);
        check("wr_err", 32'(bus.rsp_err), 32'd0);
        take_rsp();
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [2:0] rnd,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [31:0] exp_data, input logic [8:0] exp_flags,
                         input int exp_lat);
        int   cyc;
        logic ldx;
        send(1'b1, op, rnd, a, b, d, 32'h0);
        wait_rsp(80, cyc, ldx);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_data"}, bus.rsp_data, exp_data);
        check({tag, "_flags"}, 32'(bus.rsp_flags), 32'(exp_flags));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
        take_rsp();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstp = 1'b0;
        @(negedge clk);
        rstp = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        int   seen;
        logic ldx;

        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_round = 3'd0;
        bus.cmd_a     = 5'd0;
        bus.cmd_b     = 5'd0;
        bus.cmd_d     = 5'd0;
        bus.cmd_data  = 32'h0;
        bus.rsp_ready = 1'b0;
        m_kill        = 1'b0;
        rstp          = 1'b1;
        #2 rstp = 1'b0;
        #1;
        check("rst_enable", 32'(fpu_enable), 32'd1);
        check("rst_ld", 32'(fpu_ld), 32'd0);
        check("rst_addr3", 32'(fpu_addr3), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        repeat (3) @(negedge clk);
        rstp = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // add r1 + r2 -> r3, then hold the response for 10 cycles
        do_write(5'd1, 32'h3F800000);
        do_write(5'd2, 32'h40000000);
        send(1'b1, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        wait_rsp(40, cyc, ldx);
        check("add_lat", cyc, 7);
        check("add_data", bus.rsp_data, 32'h40400000);
        check("add_flags", 32'(bus.rsp_flags), 32'd0);
        check("add_err", 32'(bus.rsp_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data", bus.rsp_data, 32'h40400000);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        take_rsp();
        @(negedge clk);
        check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rel_valid", 32'(bus.rsp_valid), 32'd0);
        check("add_wb_r3", mem[3], 32'h40400000);

        // div by zero
        do_write(5'd4, 32'h3F800000);
        do_write(5'd5, 32'h00000000);
        do_op("div", 3'd2, 3'd1, 5'd4, 5'd5, 5'd6, 32'h7F800000, 9'h010, 13);
        check("div_wb_r6", mem[6], 32'h7F800000);

        // mul 2 * 3, compare 1 vs 2
        do_write(5'd8, 32'h40400000);
        do_op("mul", 3'd1, 3'd2, 5'd2, 5'd8, 5'd9, 32'h40C00000, 9'h000, 7);
        do_op("cmp", 3'd4, 3'd0, 5'd1, 5'd2, 5'd7, 32'h00000000, 9'h008, 7);

        // illegal opcode
        send(1'b1, 3'd6, 3'd0, 5'd1, 5'd2, 5'd13, 32'h0);
        wait_rsp(10, cyc, ldx);
        check("ill_lat_le2", 32'(cyc <= 2), 32'd1);
        check("ill_ld_never", 32'(ldx), 32'd0);
        check("ill_err", 32'(bus.rsp_err), 32'd1);
        check("ill_flags", 32'(bus.rsp_flags), 32'd0);
        check("ill_data", bus.rsp_data, 32'h0);
        take_rsp();

        // sqrt 4 -> 2
        do_write(5'd10, 32'h40800000);
        do_op("sqrt", 3'd3, 3'd3, 5'd10, 5'd0, 5'd11, 32'h40000000, 9'h000, 13);

        // reset in the middle of a sqrt EXEC
        send(1'b1, 3'd3, 3'd3, 5'd10, 5'd0, 5'd14, 32'h0);
        @(negedge clk);
        check("ld0_ld", 32'(fpu_ld), 32'd1);
        check("ld0_opcode", 32'(fpu_opcode), 32'd3);
        check("ld0_round", 32'(fpu_round), 32'd3);
        check("ld0_addr1", 32'(fpu_addr1), 32'd10);
        check("ld0_addr3", 32'(fpu_addr3), 32'd14);
        repeat (2) @(negedge clk);
        check("exec_ld", 32'(fpu_ld), 32'd0);
        check("exec_addr3", 32'(fpu_addr3), 32'd14);
        @(negedge clk);
        #2 rstp = 1'b0;
        #1;
        check("mrst_enable", 32'(fpu_enable), 32'd1);
        check("mrst_ld", 32'(fpu_ld), 32'd0);
        check("mrst_addrs", {17'h0, fpu_addr1, fpu_addr2, fpu_addr3}, 32'h0);
        check("mrst_op_rnd", {26'h0, fpu_opcode, fpu_round}, 32'h0);
        check("mrst_inp", fpu_inp, 32'h0);
        check("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mrst_rsp_data", bus.rsp_data, 32'h0);
        check("mrst_rsp_flags_err", {22'h0, bus.rsp_flags, bus.rsp_err}, 32'h0);
        @(negedge clk);
        rstp = 1'b1;

        // FPU never signals done
        m_kill = 1'b1;
        send(1'b1, 3'd1, 3'd0, 5'd2, 5'd8, 5'd15, 32'h0);
`ifdef FPU_SEQ_TIMEOUT_EN
        wait_rsp(60, cyc, ldx);
        check("to_lat", cyc, 35);
        check("to_err", 32'(bus.rsp_err), 32'd1);
        check("to_flags", 32'(bus.rsp_flags), 32'h001);
        check("to_data", bus.rsp_data, 32'h0);
        take_rsp();
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("nodone_no_rsp", seen, 0);
`endif
        apply_reset();
        m_kill = 1'b0;

        // add still works after the reset
        do_op("add2", 3'd0, 3'd0, 5'd1, 5'd2, 5'd12, 32'h40400000, 9'h000, 7);
        check("add2_wb_r12", mem[12], 32'h40400000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
